frog_lfsr_bank: RTL and testbench



---
 rtl/frog_lfsr_bank_if.sv | 39 +++
 rtl/frog_lfsr_bank.sv | 131 +++++++++++++
 tb/tb_frog_lfsr_bank.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/frog_lfsr_bank_if.sv
// ---------------------------------------------------------------------------
// frog_lfsr_bank_if
// Bundles the load port, per-channel enables/outputs and the readback port of
// frog_lfsr_bank. clk and rst_n stay plain ports on the design.
//   load, load_ch, prog, seed, mode : program one channel (taps/seed/mode)
//   enable                          : per-channel step enable
//   out, lockup                     : per-channel output bit and sticky lockup
//   rd_sel                          : readback channel select
//   state_out, period_out, period_vld : readback of channel rd_sel
// The tap-mask input is called prog because "program" is an SV keyword.
// ---------------------------------------------------------------------------
interface frog_lfsr_bank_if #(
  parameter int N  = 8,
  parameter int CH = 4,
  parameter int CW = (CH > 1) ? $clog2(CH) : 1
);
  logic          load;
  logic [CW-1:0] load_ch;
  logic [N-1:0]  prog;
  logic [N-1:0]  seed;
  logic          mode;
  logic [CH-1:0] enable;
  logic [CH-1:0] out;
  logic [CH-1:0] lockup;
  logic [CW-1:0] rd_sel;
  logic [N-1:0]  state_out;
  logic [N-1:0]  period_out;
  logic          period_vld;

  modport master (
    output load, load_ch, prog, seed, mode, enable, rd_sel,
    input  out, lockup, state_out, period_out, period_vld
  );

  modport slave (
    input  load, load_ch, prog, seed, mode, enable, rd_sel,
    output out, lockup, state_out, period_out, period_vld
  );
endinterface

// File: rtl/frog_lfsr_bank.sv
// ---------------------------------------------------------------------------
// frog_lfsr_bank
// CH independent N-bit LFSRs (Fibonacci or Galois per channel) with per-channel
// enable, all-zero lockup recovery and period measurement against the seed.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus_if : frog_lfsr_bank_if.slave (load port, enables, outputs, readback)
// ---------------------------------------------------------------------------
module frog_lfsr_bank #(
  parameter int N  = 8,
  parameter int CH = 4,
  parameter int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  frog_lfsr_bank_if.slave  bus_if
);

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] ONE     = N'(1);

  typedef struct packed {
    logic [N-1:0] state;
    logic [N-1:0] seed;
    logic [N-1:0] taps;
    logic [N-1:0] cnt;
    logic [N-1:0] period;
    logic         mode;    // 0 = Fibonacci, 1 = Galois
    logic         vld;
    logic         lockup;
  } chan_t;

  // Per-channel views gathered for the output vectors and readback mux.
  logic [N-1:0] state_a  [CH];
  logic [N-1:0] period_a [CH];
  logic         vld_a    [CH];
  logic         lockup_a [CH];

  for (genvar c = 0; c < CH; c++) begin : g_ch
    chan_t        ch_q, ch_d;
    logic [N-1:0] nxt;
    logic         sel;

    // Out-of-range load_ch never matches, so such loads are ignored.
    assign sel = bus_if.load && (int'(bus_if.load_ch) == c);

    always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the branches below can leave a latch behind.
      ch_d = ch_q;
      if (ch_q.mode) begin
        nxt = {ch_q.state[N-2:0], 1'b0} ^ ({N{ch_q.state[N-1]}} & ch_q.taps);
      end else begin
        nxt = {ch_q.state[N-2:0], ^(ch_q.state & ch_q.taps)};
      end

      if (sel) begin
        ch_d.taps = bus_if.prog;
        ch_d.mode = bus_if.mode;
        ch_d.cnt  = '0;
        ch_d.vld  = 1'b0;
        if (bus_if.seed != '0) begin
          ch_d.seed   = bus_if.seed;
          ch_d.state  = bus_if.seed;
          ch_d.lockup = 1'b0;
        end else begin
          // A zero seed would lock the register; substitute 1 and flag it.
          ch_d.seed   = ONE;
          ch_d.state  = ONE;
          ch_d.lockup = 1'b1;
        end
      end else if (bus_if.enable[c]) begin
        if (nxt == '0) begin
          // Lockup recovery: restart from the seed, no period for this lap.
          ch_d.state  = ch_q.seed;
          ch_d.lockup = 1'b1;
          ch_d.cnt    = '0;
        end else begin
          ch_d.state = nxt;
          if (nxt == ch_q.seed) begin
            ch_d.cnt = '0;
            // A saturated count means the true period is unknown.
            if (ch_q.cnt != CNT_MAX) begin
              ch_d.period = ch_q.cnt + ONE;
              ch_d.vld    = 1'b1;
            end
          end else if (ch_q.cnt != CNT_MAX) begin
            ch_d.cnt = ch_q.cnt + ONE;
          end
        end
      end
    end

    // NOTE: sequential state uses non-blocking assignment only, so every
    // register samples the pre-edge values regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: the whole per-channel register set is reset because every
        // field has an externally visible reset value (state/seed = 1).
        ch_q <= '{state: ONE, seed: ONE, taps: '0, cnt: '0, period: '0,
                  mode: 1'b0, vld: 1'b0, lockup: 1'b0};
      end else begin
        ch_q <= ch_d;
      end
    end

    assign state_a[c]  = ch_q.state;
    assign period_a[c] = ch_q.period;
    assign vld_a[c]    = ch_q.vld;
    assign lockup_a[c] = ch_q.lockup;
  end

  always_comb begin
    bus_if.out        = '0;
    bus_if.lockup     = '0;
    bus_if.state_out  = '0;
    bus_if.period_out = '0;
    bus_if.period_vld = 1'b0;
    for (int c = 0; c < CH; c++) begin
      bus_if.out[c]    = state_a[c][N-1];
      bus_if.lockup[c] = lockup_a[c];
      // rd_sel beyond the last channel matches nothing and reads zero.
      if (int'(bus_if.rd_sel) == c) begin
        bus_if.state_out  = state_a[c];
        bus_if.period_out = period_a[c];
        bus_if.period_vld = vld_a[c];
      end
    end
  end

endmodule

// File: tb/tb_frog_lfsr_bank.sv
// ---------------------------------------------------------------------------
// tb_frog_lfsr_bank
// Directed bench for frog_lfsr_bank (N=8, CH=4) plus a CH=3 instance used to
// exercise out-of-range load_ch / rd_sel values.
// ---------------------------------------------------------------------------
module tb_frog_lfsr_bank;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  frog_lfsr_bank_if #(.N(8), .CH(4)) bus ();
  frog_lfsr_bank_if #(.N(8), .CH(3)) bus3 ();

  frog_lfsr_bank #(.N(8), .CH(4)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  frog_lfsr_bank #(.N(8), .CH(3)) u_dut3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input int ch, input logic [7:0] p,
                         input logic [7:0] s, input logic m);
    bus.load    = 1'b1;
    bus.load_ch = 2'(ch);
    bus.prog    = p;
    bus.seed    = s;
    bus.mode    = m;
    step(1);
    bus.load    = 1'b0;
  endtask

  task automatic rd(input int ch);
    bus.rd_sel = 2'(ch);
    #1;
  endtask

  logic       seq [300];
  int         mism;
  logic [7:0] e;

  initial begin
    rst_n = 1'b0;
    bus.load = 1'b0;  bus.load_ch = '0; bus.prog = '0; bus.seed = '0;
    bus.mode = 1'b0;  bus.enable = '0;  bus.rd_sel = '0;
    bus3.load = 1'b0; bus3.load_ch = '0; bus3.prog = '0; bus3.seed = '0;
    bus3.mode = 1'b0; bus3.enable = '0;  bus3.rd_sel = '0;
    #12 rst_n = 1'b1;
    step(1);

    // 1. Reset values on every channel
    check("rst_out", 32'(bus.out), 32'h0);
    check("rst_lockup", 32'(bus.lockup), 32'h0);
    for (int r = 0; r < 4; r++) begin
      rd(r);
      check($sformatf("rst_state%0d", r), 32'(bus.state_out), 32'h01);
      check($sformatf("rst_vld%0d", r), 32'(bus.period_vld), 32'h0);
    end

    // 2. Channel 0 Fibonacci B8 / AA
    do_load(0, 8'hB8, 8'hAA, 1'b0);
    rd(0);
    check("ch0_load_state", 32'(bus.state_out), 32'hAA);
    check("ch0_first_bit", 32'(bus.out[0]), 32'h1);
    bus.enable = 4'b0001;
    for (int i = 0; i < 300; i++) begin
      seq[i] = bus.out[0];
      step(1);
      if (i == 0)   check("ch0_step1", 32'(bus.state_out), 32'h55);
      if (i == 253) check("ch0_vld_254", 32'(bus.period_vld), 32'h0);
      if (i == 254) begin
        check("ch0_state_255", 32'(bus.state_out), 32'hAA);
        check("ch0_vld_255", 32'(bus.period_vld), 32'h1);
        check("ch0_period", 32'(bus.period_out), 32'd255);
      end
    end
    bus.enable = 4'b0000;
    mism = 0;
    for (int i = 255; i < 300; i++) if (seq[i] !== seq[i-255]) mism++;
    check("ch0_repeat", 32'(mism), 32'h0);

    // 3. Channel 1 Galois 1D / 01, concurrent with channel 0
    do_load(0, 8'hB8, 8'hAA, 1'b0);
    do_load(1, 8'h1D, 8'h01, 1'b1);
    rd(0);
    check("ch0_reload_vld", 32'(bus.period_vld), 32'h0);
    rd(1);
    bus.enable = 4'b0011;
    for (int i = 1; i <= 255; i++) begin
      step(1);
      if (i <= 8) begin
        e = (i < 8) ? 8'(1 << i) : 8'h1D;
        check($sformatf("ch1_step%0d", i), 32'(bus.state_out), 32'(e));
      end
    end
    bus.enable = 4'b0000;
    check("ch1_state_255", 32'(bus.state_out), 32'h01);
    check("ch1_period", 32'(bus.period_out), 32'd255);
    check("ch1_vld", 32'(bus.period_vld), 32'h1);
    rd(0);
    check("ch0_conc_state", 32'(bus.state_out), 32'hAA);
    check("ch0_conc_period", 32'(bus.period_out), 32'd255);

    // 4. Channel 2 zero seed and lockup recovery
    do_load(2, 8'h00, 8'h00, 1'b0);
    rd(2);
    check("ch2_zero_lockup", 32'(bus.lockup[2]), 32'h1);
    check("ch2_zero_state", 32'(bus.state_out), 32'h01);
    do_load(2, 8'h00, 8'h01, 1'b0);
    check("ch2_load_clear", 32'(bus.lockup[2]), 32'h0);
    bus.enable = 4'b0100;
    step(7);
    check("ch2_step7", 32'(bus.state_out), 32'h80);
    step(1);
    bus.enable = 4'b0000;
    check("ch2_recover_state", 32'(bus.state_out), 32'h01);
    check("ch2_recover_lockup", 32'(bus.lockup[2]), 32'h1);
    check("ch2_recover_vld", 32'(bus.period_vld), 32'h0);
    do_load(2, 8'h00, 8'h01, 1'b0);
    check("ch2_reload_clear", 32'(bus.lockup[2]), 32'h0);

    // 5. Load channel 3 while all channels are enabled
    do_load(0, 8'hB8, 8'hAA, 1'b0);
    do_load(1, 8'h1D, 8'h01, 1'b1);
    bus.enable = 4'hF;
    do_load(3, 8'hB8, 8'h5A, 1'b0);
    bus.enable = 4'h0;
    rd(0); check("sim_ch0", 32'(bus.state_out), 32'h55);
    rd(1); check("sim_ch1", 32'(bus.state_out), 32'h02);
    rd(2); check("sim_ch2", 32'(bus.state_out), 32'h02);
    rd(3); check("sim_ch3", 32'(bus.state_out), 32'h5A);

    // 5b. CH=3 instance: load_ch=3 and rd_sel=3 are out of range
    bus3.load = 1'b1; bus3.load_ch = 2'd3; bus3.seed = 8'h5A; bus3.prog = 8'hB8;
    step(1);
    bus3.load = 1'b0;
    for (int r = 0; r < 3; r++) begin
      bus3.rd_sel = 2'(r);
      #1;
      check($sformatf("oor_state%0d", r), 32'(bus3.state_out), 32'h01);
    end
    check("oor_lockup", 32'(bus3.lockup), 32'h0);
    bus3.rd_sel = 2'd3;
    #1;
    check("oor_rd_state", 32'(bus3.state_out), 32'h0);
    check("oor_rd_vld", 32'(bus3.period_vld), 32'h0);

    // 6. Non-invertible taps (bit7 clear) on channel 3
    do_load(3, 8'h01, 8'h81, 1'b0);
    rd(3);
    bus.enable = 4'b1000;
    step(1);
    check("ni_step1", 32'(bus.state_out), 32'h03);
    step(299);
    bus.enable = 4'b0000;
    check("ni_sat_state", 32'(bus.state_out), 32'hFF);
    check("ni_sat_vld", 32'(bus.period_vld), 32'h0);
    check("ni_sat_lockup", 32'(bus.lockup[3]), 32'h0);
    do_load(3, 8'h38, 8'h80, 1'b0);
    bus.enable = 4'b1000;
    step(1);
    bus.enable = 4'b0000;
    check("ni_lock_state", 32'(bus.state_out), 32'h80);
    check("ni_lock_flag", 32'(bus.lockup[3]), 32'h1);
    check("ni_lock_vld", 32'(bus.period_vld), 32'h0);
    do_load(3, 8'h38, 8'hFF, 1'b0);
    bus.enable = 4'b1000;
    step(1);
    bus.enable = 4'b0000;
    check("ni_fixed_state", 32'(bus.state_out), 32'hFF);
    check("ni_fixed_period", 32'(bus.period_out), 32'd1);
    check("ni_fixed_vld", 32'(bus.period_vld), 32'h1);

    // 7. Asynchronous reset mid-run, then taps are gone
    do_load(0, 8'hB8, 8'hAA, 1'b0);
    rd(0);
    bus.enable = 4'hF;
    step(3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(bus.state_out), 32'h01);
    check("arst_out", 32'(bus.out), 32'h0);
    check("arst_lockup", 32'(bus.lockup), 32'h0);
    bus.enable = 4'h1;
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    bus.enable = 4'h0;
    check("arst_taps_lost", 32'(bus.state_out), 32'h02);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
